// File: rtl/grant_pkg.sv
// Shared types and default sizing for the grant issuer.
package grant_pkg;

  localparam int GRANT_N       = 8;
  localparam int GRANT_IDX_W   = 3;
  localparam int GRANT_TIMEOUT = 16;

  // Fixed encodings so the state values stay stable for older tooling and probes.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT   = ST_GRANT,
    RELEASE = ST_RELEASE
  } state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Index plus enable to one-hot vector; the inverse of the request priority encoder.
// Indices at or above N produce an all-zero vector.
module onehot_decoder
  import grant_pkg::*;
#(
  parameter int N     = GRANT_N,
  parameter int IDX_W = GRANT_IDX_W
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     vec
);

  // Set the single bit whose position matches idx when enabled.
  always_comb begin
    vec = '0;
    for (int i = 0; i < N; i++) begin
      vec[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/grant_decoder.sv
// Registered grant issuer: turns the encoded winner into a one-hot grant, holds it
// until the granted requester reports done or the grant times out, then releases.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant; waiting for valid with an in-range enc
// GRANT   | gnt one-hot on gnt_idx; counting grant length
// RELEASE | one cycle with gnt low and busy high; timeout_err flagged here
module grant_decoder
  import grant_pkg::*;
#(
  parameter int N       = GRANT_N,
  parameter int IDX_W   = GRANT_IDX_W,
  parameter int TIMEOUT = GRANT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] enc,
  input  logic             valid,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             terr_nxt;
  logic             enc_ok;
  logic [N-1:0]     gnt_nxt;

  assign enc_ok = ({1'b0, enc} < N_LIM);

  // Next-state, captured index, grant-length counter and error flag.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    cnt_nxt   = cnt;
    terr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (valid && enc_ok) begin
          state_nxt = GRANT;
          idx_nxt   = enc;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // done has priority over an expiring timer in the same cycle
        if (done[gnt_idx]) begin
          state_nxt = RELEASE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASE;
          terr_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The grant vector is decoded from next-state values so gnt itself is a flop.
  onehot_decoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx (idx_nxt),
    .en  (state_nxt == GRANT),
    .vec (gnt_nxt)
  );

  // State and registered outputs; reset clears everything without flagging an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gnt         <= gnt_nxt;
      gnt_idx     <= idx_nxt;
      busy        <= (state_nxt != IDLE);
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Scoreboard bench for grant_decoder: the driver pushes the expected grant for every
// request it issues; a monitor pops and checks whenever a grant appears and ends.
module tb_grant_decoder;

  localparam int N       = 8;
  localparam int IDX_W   = 3;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [IDX_W-1:0] enc;
  logic             valid;
  logic [N-1:0]     done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             timeout_err;

  grant_decoder #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enc         (enc),
    .valid       (valid),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int len;
    int terr;
    int gap;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;
  bit   mon_en   = 1'b0;
  bit   first_txn = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a grant lasts until the cycle done arrives, capped at TIMEOUT cycles;
  // the error flag is raised only if done never arrived within that window.
  task automatic run_grant(input int e, input int d, input int w,
                           input logic [N-1:0] fixed_noise, input bit use_fixed);
    exp_t x;
    logic [N-1:0] bit_e;
    logic [N-1:0] noise;
    int len;
    bit_e = '0;
    bit_e[e] = 1'b1;
    len = (d <= TIMEOUT) ? d : TIMEOUT;
    repeat (w) begin
      @(negedge clk);
      valid = 1'b0;
      enc   = IDX_W'($urandom);
      done  = N'($urandom);
    end
    @(negedge clk);
    valid  = 1'b1;
    enc    = IDX_W'(e);
    done   = N'($urandom);
    x.idx  = e;
    x.len  = len;
    x.terr = (d > TIMEOUT) ? 1 : 0;
    x.gap  = first_txn ? -1 : (w + 2);
    first_txn = 1'b0;
    sbq.push_back(x);
    pushed++;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      valid = 1'($urandom);
      enc   = IDX_W'($urandom);
      noise = use_fixed ? fixed_noise : N'($urandom);
      done  = (noise & ~bit_e) | ((c == d) ? bit_e : '0);
    end
    // release cycle: everything on the inputs must be ignored
    @(negedge clk);
    valid = 1'($urandom);
    enc   = IDX_W'($urandom);
    done  = N'($urandom);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  bit          in_run   = 1'b0;
  bit          rel_next = 1'b0;
  int          run_len  = 0;
  int          low_cnt  = 0;
  logic [N-1:0] run_gnt;
  exp_t        cur;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (gnt != '0) begin
        if (!in_run) begin
          chk("onehot", $countones(gnt), 1);
          if (sbq.size() == 0) begin
            chk("unexpected_grant", int'(gnt), 0);
            cur.idx = int'(gnt_idx); cur.len = 0; cur.terr = 0; cur.gap = -1;
          end else begin
            cur = sbq.pop_front();
            popped++;
          end
          chk("gnt_vector", int'(gnt), 1 << cur.idx);
          if (cur.gap >= 0) chk("gap", low_cnt, cur.gap);
          in_run  = 1'b1;
          run_len = 1;
          run_gnt = gnt;
        end else begin
          chk("gnt_stable", int'(gnt), int'(run_gnt));
          run_len++;
        end
        chk("busy_grant", int'(busy), 1);
        chk("terr_grant", int'(timeout_err), 0);
        chk("idx_grant", int'(gnt_idx), cur.idx);
        low_cnt  = 0;
        rel_next = 1'b0;
      end else begin
        low_cnt++;
        if (in_run) begin
          in_run = 1'b0;
          chk("grant_len", run_len, cur.len);
          chk("terr_release", int'(timeout_err), cur.terr);
          chk("busy_release", int'(busy), 1);
          chk("idx_release", int'(gnt_idx), cur.idx);
          rel_next = 1'b1;
        end else if (rel_next) begin
          chk("busy_idle", int'(busy), 0);
          chk("terr_idle", int'(timeout_err), 0);
          chk("idx_hold", int'(gnt_idx), cur.idx);
          rel_next = 1'b0;
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    enc   = '0;
    done  = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_idx", int'(gnt_idx), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_terr", int'(timeout_err), 0);
    mon_en = 1'b1;

    // one-hot sweep with done three cycles in
    for (int e = 0; e < N; e++) run_grant(e, 3, e % 2, '0, 1'b1);
    // timeout with done never asserted
    run_grant(5, 100, 1, '0, 1'b1);
    // wrong done bit held, then the right one
    run_grant(2, 4, 0, 8'b0001_0000, 1'b1);
    // done and timeout collide on the last cycle
    run_grant(6, TIMEOUT, 0, '0, 1'b0);
    // done on the first grant cycle
    run_grant(0, 1, 2, '0, 1'b0);
    // back-to-back
    run_grant(7, 2, 0, '0, 1'b0);
    run_grant(1, 5, 0, '0, 1'b0);
    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_grant(int'($urandom_range(0, N - 1)), int'($urandom_range(1, TIMEOUT + 4)),
                int'($urandom_range(0, 3)), '0, 1'b0);
    end

    repeat (4) begin
      @(negedge clk);
      valid = 1'b0;
      done  = '0;
    end
    chk("all_grants_seen", popped, pushed);
    chk("queue_empty", sbq.size(), 0);
    mon_en = 1'b0;

    // asynchronous reset in the middle of a grant on index 3
    @(negedge clk);
    valid = 1'b1;
    enc   = 3'd3;
    done  = '0;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_gnt", int'(gnt), 8);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_terr", int'(timeout_err), 0);
    chk("async_rst_idx", int'(gnt_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", int'(gnt), 0);
    chk("post_rst_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Registered grant issuer: the consumer end of the priority encoder's request path. Takes the encoded winner index (`enc`, `valid`) produced by the priority encoder and drives a one-hot grant to the selected requester. Holds the grant until that requester signals completion or a timeout expires, then releases and returns to idle. It sits between the request encoder and the eight requester ports.

## Interface
- `N`, 8: number of requesters; width of `gnt` and `done`.
- `IDX_W`, 3: index width; must satisfy `N` ≤ 2**`IDX_W`.
- `TIMEOUT`, 16: maximum grant length in cycles; must be ≥ 2.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enc`  in  `IDX_W`  encoded winning requester index.
- `valid`  in  1  `enc` is meaningful (at least one request pending).
- `done`  in  `N`  per-requester completion; only bit `gnt_idx` is honoured.
- `gnt`  out  `N`  one-hot grant, or all-zero.
- `gnt_idx`  out  `IDX_W`  index of the current/last grant.
- `busy`  out  1  high in GRANT and RELEASE.
- `timeout_err`  out  1  one-cycle pulse when a grant ended by timeout.

## Operation
- All outputs are registered. Reset forces: state=IDLE, `gnt`=0, `gnt_idx`=0, `busy`=0, `timeout_err`=0, counter=0.
- The FSM has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - `gnt`=0, `busy`=0.
  - On `valid`=1 with `enc` < `N`: capture `enc` into `gnt_idx`, clear the counter, go to GRANT.
  - `valid` with `enc` ≥ `N` is ignored; the FSM stays in IDLE.
- GRANT:
  - `gnt` = one-hot(`gnt_idx`), `busy`=1, counter increments each cycle.
  - `done[gnt_idx]`=1 → RELEASE, `timeout_err`=0.
  - Otherwise, counter == `TIMEOUT`-1 → RELEASE, `timeout_err`=1.
  - If `done` and timeout occur in the same cycle, `done` wins and no error is flagged.
  - `done` bits other than `gnt_idx` are ignored.
- RELEASE:
  - `gnt`=0, `busy`=1 for exactly one cycle, then IDLE.
  - `timeout_err` is high only in this cycle, and only when the timeout path was taken.
- `valid`/`enc` are ignored outside IDLE. Requests are not queued; the requester keeps `valid` asserted upstream.
- `gnt_idx` holds its value after release until the next capture.
- Reset mid-grant drops `gnt` to zero asynchronously and no error is reported.

## Timing
- Grant latency: `valid` sampled at edge k → `gnt` high after edge k.
- Release: `done` sampled at edge m → `gnt` low after edge m.
- A `done` already high on the first GRANT cycle gives a 1-cycle grant.
- Timeout grant: exactly `TIMEOUT` cycles of `gnt` high.
- Back-to-back: minimum `gnt` low gap between grants is 2 cycles (RELEASE, then IDLE sampling `valid`).
- `gnt` is never multi-hot, including across transitions.

## Structure
- Package `grant_pkg`:
  - `state_t` enum (IDLE, GRANT, RELEASE).
  - Default constants `GRANT_N`=8, `GRANT_IDX_W`=3, `GRANT_TIMEOUT`=16.
- Sub-module `onehot_decoder` (combinational, parameterised on `N`/`IDX_W`): index plus enable → one-hot vector. This is the inverse of the priority encoder and is reusable elsewhere.
- Counter width: $clog2(`TIMEOUT`).

## Test plan
- Reset: assert `rst` mid-GRANT with `gnt`=00001000 → `gnt`=0, `busy`=0, `timeout_err`=0 immediately, without waiting for a clock edge.
- One-hot sweep: for `enc`=0..7 with `valid`=1, then `done[enc]` 3 cycles later → `gnt`=1<<`enc` for 3 cycles, then one RELEASE cycle, `timeout_err`=0.
- Timeout: `enc`=5, `done` held 0 → `gnt`=00100000 for exactly 16 cycles, then `timeout_err`=1 for one cycle, `gnt_idx`=5.
- Wrong done: grant on `enc`=2, pulse `done`=00000100 only after `done`=00010000 is asserted → the grant ignores bit 4 and releases on bit 2.
- Collision: `done[idx]` asserted on cycle 16 of the grant → release with `timeout_err`=0.
- Back-to-back: `valid` held with `enc`=7 then `enc`=1 → two grants separated by exactly 2 low cycles; `valid` changes during GRANT have no effect.
